// File: rtl/gf163_pkg.sv
// Shared GF(2^163) definitions: field width, reduction polynomial, constants, sequencer states.
package gf163_pkg;

    localparam int unsigned M     = 163;
    localparam int unsigned CNT_W = 8;

    // F = x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M:0]   F   = {1'b1, 155'b0, 8'hC9};
    localparam logic [M-1:0] ONE = M'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/karatsuba_mult163_red.sv
// Combinational GF(2^163) multiplier: one-level Karatsuba carry-less multiply, then reduction mod F.
//   x, y : field operands (LSB = x^0)
//   z    : x*y mod F
module karatsuba_mult163_red
    import gf163_pkg::*;
(
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic [M-1:0] z
);

    localparam int unsigned H  = 82;          // low half width; high half is M-H = 81 bits
    localparam int unsigned PW = 2*H - 1;     // half-product width
    localparam int unsigned FW = 2*M - 1;     // full product width

    // Schoolbook carry-less multiply of two H-bit halves
    function automatic logic [PW-1:0] clmul(input logic [H-1:0] u, input logic [H-1:0] v);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(H); i++) begin
            if (u[i]) acc = acc ^ (PW'(v) << i);
        end
        return acc;
    endfunction

    logic [H-1:0]  x0, x1, y0, y1;
    logic [PW-1:0] p0, p2, pm, mid;
    logic [FW-1:0] full;
    logic [FW-1:0] t;

    assign x0 = x[H-1:0];
    assign y0 = y[H-1:0];
    assign x1 = {1'b0, x[M-1:H]};
    assign y1 = {1'b0, y[M-1:H]};

    assign p0  = clmul(x0, y0);
    assign p2  = clmul(x1, y1);
    assign pm  = clmul(x0 ^ x1, y0 ^ y1);
    assign mid = pm ^ p0 ^ p2;

    assign full = FW'(p0) ^ (FW'(mid) << H) ^ (FW'(p2) << (2*H));

    // Fold high bits down from the top so re-set bits above M-1 are reduced again
    always_comb begin
        t = full;
        for (int i = int'(FW) - 1; i >= int'(M); i--) begin
            if (t[i]) t[i -: M+1] = t[i -: M+1] ^ F;
        end
        z = t[M-1:0];
    end

endmodule

// File: rtl/gf163_inv_seq.sv
// Multiply / Fermat-inversion sequencer around a single shared GF(2^163) multiplier.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake; op_inv selects a*b (0) or a^-1 (1)
//   a, b                : operands (b unused for inversion)
//   out_valid/out_ready : result handshake; result held while out_ready=0
//   busy                : high outside IDLE
module gf163_inv_seq
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_inv,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result,
    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 2);

    state_t           state;
    logic [M-1:0]     s, r;
    logic [CNT_W-1:0] cnt;
    logic [M-1:0]     mul_x, mul_z;

    // Operand mux: squaring uses (s,s), accumulate uses (r,s)
    assign mul_x = (state == SQR) ? s : r;

    karatsuba_mult163_red u_mult (
        .x (mul_x),
        .y (s),
        .z (mul_z)
    );

    // Sequencer: a^-1 = prod_{i=1..M-1} a^(2^i), one square + one multiply per iteration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            r         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s        <= a;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        if (op_inv) begin
                            r     <= ONE;
                            cnt   <= '0;
                            state <= SQR;
                        end else begin
                            // Preset counter to the last value so only one multiply runs
                            r     <= b;
                            cnt   <= CNT_LAST;
                            state <= MUL;
                        end
                    end
                end
                SQR: begin
                    s     <= mul_z;
                    state <= MUL;
                end
                MUL: begin
                    r <= mul_z;
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= mul_z;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf163_inv_seq.sv
module tb_gf163_inv_seq;

    localparam int W = 163;
    localparam int LIMIT = 1000;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_inv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks;
    int errors;

    localparam logic [W-1:0] INV_X   = {1'b1, 155'b0, 7'h64};
    localparam logic [W-1:0] X162    = {1'b1, 162'b0};
    localparam logic [W-1:0] K_ONE   = 163'd1;

    gf163_inv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_inv    (op_inv),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait for the result, complete the handshake
    task automatic run_op(input logic op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          output logic [W-1:0] res, output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        op_inv   = op;
        a        = aa;
        b        = bb;
        guard    = 0;
        while (!in_ready && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL run_op_timeout: out_valid=%0b required 1", out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        if (result !== '0)      begin errors++; $display("FAIL reset_result: got %h required 0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op_inv = 1'b1; a = 163'd2; b = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %0b required 0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %0b required 1", in_ready); end
        if (result !== '0)      begin errors++; $display("FAIL midrst_result: got %h required 0", result); end
        rst_n = 1'b1;
        run_op(1'b1, 163'd2, '0, res, lat);
        checks++;
        if (res !== INV_X) begin errors++; $display("FAIL midrst_rerun: got %h required %h", res, INV_X); end
    endtask

    task automatic test_inv_x();
        logic [W-1:0] res;
        int lat;
        run_op(1'b1, 163'd2, '0, res, lat);
        checks += 2;
        if (res !== INV_X) begin errors++; $display("FAIL inv_x_result: got %h required %h", res, INV_X); end
        if (lat != 324)    begin errors++; $display("FAIL inv_x_latency: got %0d required 324", lat); end
    endtask

    task automatic test_trivial();
        logic [W-1:0] res;
        int lat;
        run_op(1'b1, 163'd1, '0, res, lat);
        checks++;
        if (res !== K_ONE) begin errors++; $display("FAIL inv_one: got %h required 1", res); end
        run_op(1'b1, 163'd0, '0, res, lat);
        checks++;
        if (res !== '0) begin errors++; $display("FAIL inv_zero: got %h required 0", res); end
        run_op(1'b0, X162, 163'd2, res, lat);
        checks += 2;
        if (res !== 163'hC9) begin errors++; $display("FAIL mul_wrap: got %h required c9", res); end
        if (lat != 1)        begin errors++; $display("FAIL mul_latency: got %0d required 1", lat); end
        run_op(1'b0, 163'h5, 163'h3, res, lat);
        checks++;
        if (res !== 163'hF) begin errors++; $display("FAIL mul_small: got %h required f", res); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held, res;
        int lat;
        int bad;
        @(negedge clk);
        in_valid = 1'b1; op_inv = 1'b1; a = 163'd3; b = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 324) begin errors++; $display("FAIL bp_latency: got %0d required 324", lat); end
        held = result;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_valid: got %0b required 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_in_ready: got %0b required 1", in_ready); end
        run_op(1'b0, held, 163'd3, res, lat);
        checks++;
        if (res !== K_ONE) begin errors++; $display("FAIL bp_inv3_check: got %h required 1", res); end
    endtask

    task automatic test_ignored();
        int lat;
        int bad;
        @(negedge clk);
        in_valid = 1'b1; op_inv = 1'b1; a = 163'd2; b = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        repeat (10) begin @(posedge clk); #1; lat++; end
        in_valid = 1'b1; op_inv = 1'b0; a = 163'd5; b = 163'd7;
        repeat (3) begin @(posedge clk); #1; lat++; end
        in_valid = 1'b0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks += 2;
        if (lat != 324)       begin errors++; $display("FAIL ign_latency: got %0d required 324", lat); end
        if (result !== INV_X) begin errors++; $display("FAIL ign_result: got %h required %h", result, INV_X); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ign_not_queued: %0d busy cycles required 0", bad); end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, inv, res;
        int lat;
        for (int n = 0; n < 50; n++) begin
            ra = 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            if (ra == '0) ra = 163'd7;
            run_op(1'b1, ra, '0, inv, lat);
            run_op(1'b0, inv, ra, res, lat);
            checks++;
            if (res !== K_ONE) begin errors++; $display("FAIL rnd_inv_mul[%0d]: got %h required 1", n, res); end
            run_op(1'b1, inv, '0, res, lat);
            checks++;
            if (res !== ra) begin errors++; $display("FAIL rnd_inv_inv[%0d]: got %h required %h", n, res, ra); end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_inv    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_inv_x();
        test_trivial();
        test_backpressure();
        test_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
